// File: rtl/rv_pkg.sv
// Shared definitions for the pipelined RV32I core: data width default,
// register-file state encoding and the hardwired-zero register address.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rv_scoreboard.sv
// Per-register pending bits for RAW hazard detection. Same-edge priority is
// flush < write-clear < claim-set; busy is masked by a retiring write.
module rv_scoreboard import rv_pkg::*; #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic               claim_en,
  input  logic [AW-1:0]      claim_addr,
  input  logic               flush,
  input  logic [NREAD*AW-1:0] rs_addr,
  output logic [NREAD-1:0]   rs_busy
);

  logic [NREGS-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (run) begin
      if (flush) begin
        pending_d = '0;
      end
      if (wr_en) begin
        pending_d[wr_addr] = 1'b0;
      end
      if (claim_en) begin
        pending_d[claim_addr] = 1'b1;
      end
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr = rs_addr[i*AW +: AW];
    assign rs_busy[i] = run && (addr != AW'(REG_ZERO)) && pending_q[addr] &&
                        !(wr_en && (wr_addr == addr));
  end

endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file with write bypass, post-reset clear sweep, debug read
// port and a hazard scoreboard.
module rv_regfile_sb import rv_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  input  logic                  flush,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          run;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign run   = (state_q == RF_RUN);
  assign ready = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    unique case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      RF_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Entry 0 is never written; the sweep and writeback share one write port.
  always_comb begin
    if (run) begin
      mem_we    = wr_en && (wr_addr != AW'(REG_ZERO));
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_we    = (cnt_q != AW'(REG_ZERO));
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rs_addr[i*AW +: AW];
    assign hit  = wr_en && (wr_addr == addr);
    assign rs_data[i*XLEN +: XLEN] = (!run || addr == AW'(REG_ZERO)) ? '0 :
                                     hit ? wr_data : regs_q[addr];
  end

  assign dbg_data = (!run || dbg_addr == AW'(REG_ZERO)) ? '0 : regs_q[dbg_addr];

  rv_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .rs_addr    (rs_addr),
    .rs_busy    (rs_busy)
  );

endmodule
